// File: rtl/out_bcd_capture.sv
// rtl/out_bcd_capture.sv - 16-bit result capture with serial double-dabble BCD conversion (option: OUT_BCD_BLANK_EN)
module out_bcd_capture (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] dataIn,
    output logic [19:0] bcd,
    output logic        valid,
    output logic        busy,
    output logic [4:0]  digitEn
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] last_val_q, last_val_d;
    logic [15:0] shift_q, shift_d;
    logic [19:0] scratch_q, scratch_d;
    logic [3:0]  count_q, count_d;
    logic [19:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic [19:0] adj;

    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 5; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        count_d    = count_q;
        bcd_d      = bcd_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (dataIn != last_val_q) begin
                    last_val_d = dataIn;
                    shift_d    = dataIn;
                    scratch_d  = 20'd0;
                    count_d    = 4'd0;
                    valid_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // Correct digits before the shift so each stays within 0..9 afterwards.
                {scratch_d, shift_d} = {adj[18:0], shift_q, 1'b0};
                count_d = count_q + 4'd1;
                if (count_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = scratch_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_val_q <= 16'd0;
            shift_q    <= 16'd0;
            scratch_q  <= 20'd0;
            count_q    <= 4'd0;
            bcd_q      <= 20'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            count_q    <= count_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign bcd   = bcd_q;
    assign valid = valid_q;
    assign busy  = busy_q;

`ifdef OUT_BCD_BLANK_EN
    logic [4:0] digit_en_q, digit_en_d;
    logic [4:0] blank_mask;

    // A digit is lit when it or any more-significant digit is nonzero; units always lit.
    always_comb begin
        blank_mask[4] = |scratch_q[19:16];
        blank_mask[3] = blank_mask[4] | (|scratch_q[15:12]);
        blank_mask[2] = blank_mask[3] | (|scratch_q[11:8]);
        blank_mask[1] = blank_mask[2] | (|scratch_q[7:4]);
        blank_mask[0] = 1'b1;
        digit_en_d    = (state_q == DONE) ? blank_mask : digit_en_q;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            digit_en_q <= 5'b00001;
        end else begin
            digit_en_q <= digit_en_d;
        end
    end

    assign digitEn = digit_en_q;
`else
    assign digitEn = 5'b11111;
`endif
endmodule

// File: doc/out_bcd_capture.md
OUT_BCD_CAPTURE -- requirements
Module: out_bcd_capture

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 The block SHALL have port dataIn, input, 16 bits: unsigned result word driven by the CPU outputWire port.
REQ-004 The block SHALL have port bcd, output, 20 bits: five packed BCD digits; [19:16] = ten-thousands, [3:0] = units.
REQ-005 The block SHALL have port valid, output, 1 bit: bcd holds the conversion of the most recently captured dataIn.
REQ-006 The block SHALL have port busy, output, 1 bit: a conversion is in progress.
REQ-007 The block SHALL have port digitEn, output, 5 bits: per-digit display enable; bit 4 = ten-thousands digit.

Function
REQ-008 The block SHALL hold an internal 16-bit lastVal register holding the last captured dataIn.
REQ-009 The block SHALL implement states IDLE, SHIFT and DONE.
REQ-010 In IDLE, on an edge where dataIn != lastVal, the block SHALL latch dataIn into lastVal and the shift register, clear the 20-bit scratch, clear the counter to 0, deassert valid and enter SHIFT.
REQ-011 In IDLE with dataIn == lastVal, the block SHALL hold all registers.
REQ-012 In SHIFT, each edge SHALL add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit and increment the counter.
REQ-013 After the 16th SHIFT edge (counter reaching 15), the block SHALL enter DONE.
REQ-014 In DONE, the block SHALL copy scratch to bcd, set valid = 1 and return to IDLE on one edge.
REQ-015 Latency: if capture occurs at edge N, bcd and valid SHALL update at edge N+17; busy SHALL be 1 from edge N through edge N+17 exclusive.
REQ-016 busy SHALL be 1 exactly in SHIFT and DONE.
REQ-017 dataIn changes during SHIFT or DONE SHALL be ignored; on return to IDLE, any dataIn != lastVal SHALL be captured on the next edge (one IDLE cycle minimum between conversions).
REQ-018 bcd and valid SHALL hold their values between conversions; valid SHALL drop only at a capture edge or on reset.
REQ-019 Input range 0..65535 SHALL convert exactly; no digit SHALL exceed 9.

Reset
REQ-020 While reset = 0, the block SHALL asynchronously force state = IDLE, lastVal = 0, scratch = 0, counter = 0, bcd = 0, valid = 0 and busy = 0.
REQ-021 Assertion of reset mid-conversion SHALL abort the conversion without updating bcd.
REQ-022 After reset release, a dataIn of 0 SHALL NOT trigger a conversion; any nonzero dataIn SHALL be captured on the first rising edge.

Configuration
REQ-023 Macro OUT_BCD_BLANK_EN SHALL select leading-zero blanking.
REQ-024 With OUT_BCD_BLANK_EN defined, digitEn bit k SHALL be 1 iff bcd digit k or any more-significant digit is nonzero; bit 0 SHALL always be 1.
REQ-025 With OUT_BCD_BLANK_EN defined, digitEn SHALL be registered and updated in DONE alongside bcd, and SHALL reset to 5'b00001.
REQ-026 With OUT_BCD_BLANK_EN undefined, digitEn SHALL be the constant 5'b11111, including during reset.

Verification
REQ-027 Reset, release, dataIn = 0x13B0 -> busy for 17 cycles, then bcd = 0x05040, valid = 1; digitEn = 5'b01111 with OUT_BCD_BLANK_EN defined, 5'b11111 without.
REQ-028 Reset, then dataIn = 30030 -> bcd = 0x30030 at capture edge + 17, valid = 1.
REQ-029 dataIn = 65535, then 0 -> bcd = 0x65535, then bcd = 0x00000 with valid = 1; digitEn = 5'b00001 with OUT_BCD_BLANK_EN defined.
REQ-030 dataIn = 1234; change to 9 at capture edge + 5 -> bcd = 0x01234 at capture edge + 17; second capture one edge after the return to IDLE, then bcd = 0x00009.
REQ-031 dataIn = 4321; reset asserted at capture edge + 8 -> outputs zero immediately; after release, 4321 recaptured and bcd = 0x04321.
REQ-032 Held dataIn = 777 after a completed conversion for 50 cycles -> busy stays 0, valid stays 1, no recapture.
